// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine with HI/LO; fixed 33-cycle latency start->done.
// No backpressure: start is ignored while busy, hi/lo only change on done or reset.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              is_div_q, neg_res_q, neg_rem_q, dbz_q;
    logic [XLEN-1:0]   opa_q, opb_q;
    logic [2*XLEN-1:0] acc_q;
    logic              busy_q, done_q, div_by_zero_q;
    logic [XLEN-1:0]   hi_q, lo_q;

    logic              sa, sb;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_trial;
    logic [2*XLEN-1:0] mul_acc_d, div_shift, div_acc_d, step_acc_d, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    always_comb begin
        sa    = op[0] & a[XLEN-1];
        sb    = op[0] & b[XLEN-1];
        a_mag = sa ? -a : a;
        b_mag = sb ? -b : b;

        // Multiply: add multiplicand into the upper half with carry, then shift right.
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (opb_q[0] ? {1'b0, opa_q} : '0);
        mul_acc_d = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: {rem, quot} in acc_q; the shifted remainder needs XLEN+1 bits.
        div_shift = {acc_q[2*XLEN-2:0], 1'b0};
        div_trial = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opb_q};
        if (div_trial[XLEN+1:XLEN] == 2'b00) begin
            div_acc_d = {div_trial[XLEN-1:0], div_shift[XLEN-1:1], 1'b1};
        end else begin
            div_acc_d = div_shift;
        end

        step_acc_d = is_div_q ? div_acc_d : mul_acc_d;
        prod_fix   = neg_res_q ? -acc_q : acc_q;
        quot_fix   = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix    = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            is_div_q      <= 1'b0;
            neg_res_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            dbz_q         <= 1'b0;
            opa_q         <= '0;
            opb_q         <= '0;
            acc_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= CALC;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        is_div_q  <= op[1];
                        neg_res_q <= sa ^ sb;
                        neg_rem_q <= sa;
                        dbz_q     <= op[1] & (b == '0);
                        opa_q     <= a_mag;
                        opb_q     <= b_mag;
                        // The dividend starts in the quotient half; multiply starts from zero.
                        acc_q     <= op[1] ? {{XLEN{1'b0}}, a_mag} : '0;
                    end
                end
                CALC: begin
                    acc_q <= step_acc_d;
                    if (!is_div_q) begin
                        opb_q <= opb_q >> 1;
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    state_q       <= IDLE;
                    busy_q        <= 1'b0;
                    done_q        <= 1'b1;
                    div_by_zero_q <= dbz_q;
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*XLEN-1:XLEN];
                        lo_q <= prod_fix[XLEN-1:0];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: vector table, handshake/reset sequences and random ops against a model.
module tb_mul_div_unit;
    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    mul_div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        logic        dbz;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic s_rst = 1'b1;
    logic busy_prev = 1'b0;
    logic [31:0] prev_hi = '0, prev_lo = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        s_rst <= rst;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint sx, sy, q, r;
        sx = $signed(x);
        sy = $signed(y);
        model = '0;
        case (o)
            2'd0: begin p = {32'h0, x} * {32'h0, y}; model = {1'b0, p}; end
            2'd1: begin q = sx * sy; model = {1'b0, q[63:0]}; end
            2'd2: begin
                if (y == 0) model = {1'b1, x, 32'hFFFFFFFF};
                else        model = {1'b0, x % y, x / y};
            end
            default: begin
                if (y == 0) begin
                    model = {1'b1, x, (x[31] ? 32'h00000001 : 32'hFFFFFFFF)};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    model = {1'b0, r[31:0], q[31:0]};
                end
            end
        endcase
    endfunction

    // Output monitor: pops the scoreboard on done, checks latency and hi/lo stability.
    always @(negedge clk) begin
        exp_t e;
        if (!s_rst) begin
            if (busy && !busy_prev) acc_cyc = cyc;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done got done=1 want done=0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("hi", {32'h0, hi}, {32'h0, e.hi});
                    chk("lo", {32'h0, lo}, {32'h0, e.lo});
                    chk("div_by_zero", {63'h0, div_by_zero}, {63'h0, e.dbz});
                    chk("latency", 64'(cyc - acc_cyc), 64'd33);
                    chk("busy_at_done", {63'h0, busy}, 64'd0);
                end
            end else begin
                chk("hold_hi", {32'h0, hi}, {32'h0, prev_hi});
                chk("hold_lo", {32'h0, lo}, {32'h0, prev_lo});
            end
        end
        prev_hi   = hi;
        prev_lo   = lo;
        busy_prev = busy;
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
        exp_t e;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        e.hi = ehi; e.lo = elo; e.dbz = edbz;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("accept_busy", {63'h0, busy}, 64'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || sb.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL timeout got busy=%0b pending=%0d want idle", busy, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[11];
        exp_t  e;
        logic [64:0] r;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int    dc[3];
        int    nacc, nd;
        logic  pb;

        vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[3]  = '{2'd2, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        vecs[4]  = '{2'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[5]  = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{2'd2, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{2'd2, 32'd9,        32'd3,        32'h00000000, 32'h00000003, 1'b0};
        vecs[9]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[10] = '{2'd3, 32'hFFFFFFF0, 32'd0,        32'hFFFFFFF0, 32'h00000001, 1'b1};

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_done", {63'h0, done}, 64'd0);
        chk("rst_dbz", {63'h0, div_by_zero}, 64'd0);
        chk("rst_hi", {32'h0, hi}, 64'd0);
        chk("rst_lo", {32'h0, lo}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            wait_idle();
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz);
        end
        wait_idle();

        // Reset in the middle of CALC: op aborted, no done, hi/lo cleared.
        issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_busy", {63'h0, busy}, 64'd0);
        chk("abort_hi", {32'h0, hi}, 64'd0);
        chk("abort_lo", {32'h0, lo}, 64'd0);
        sb.delete();
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(2'd0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        wait_idle();

        // A start pulse while busy must be ignored.
        issue(2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        repeat (5) @(negedge clk);
        op = 2'd0; a = 32'd3; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);

        // start held high: back-to-back ops, re-accepted in each done cycle.
        e.hi = 32'd0; e.lo = 32'd42; e.dbz = 1'b0;
        for (int i = 0; i < 3; i++) sb.push_back(e);
        @(negedge clk);
        op = 2'd0; a = 32'd6; b = 32'd7; start = 1'b1;
        nacc = 0; nd = 0; pb = busy;
        dc[0] = 0; dc[1] = 0; dc[2] = 0;
        for (int n = 0; n < 200 && nd < 3; n++) begin
            @(negedge clk);
            if (busy && !pb) nacc++;
            if (nacc == 3) start = 1'b0;
            if (done) begin
                dc[nd] = cyc;
                nd++;
            end
            pb = busy;
        end
        start = 1'b0;
        chk("b2b_accepts", 64'(nacc), 64'd3);
        chk("b2b_dones", 64'(nd), 64'd3);
        chk("b2b_gap1", 64'(dc[1] - dc[0]), 64'd34);
        chk("b2b_gap2", 64'(dc[2] - dc[1]), 64'd34);
        wait_idle();

        for (int i = 0; i < 1200; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0:       ra = 32'h80000000;
                1:       ra = 32'($urandom_range(0, 20));
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            r = model(ro, ra, rb);
            wait_idle();
            issue(ro, ra, rb, r[63:32], r[31:0], r[64]);
        end
        wait_idle();
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
